wb_master_bridge: RTL and testbench

- Single-outstanding Wishbone classic-cycle initiator that drives the WISHBONE slave ports of the on-chip cores (memory controller, AC97 controllers).
- Accepts one command through a valid/ready handshake and runs one Wishbone read or write cycle.
- Returns the result through a valid/ready response port.
- Adds a bus watchdog and a saturating error counter, so a hung or erroring slave is reported rather than stalling the top level.

---
 rtl/wb_master_bridge.sv | 184 ++++++++++++++++++
 tb/tb_wb_master_bridge.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_master_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : wb_master_bridge
//  Purpose  : Single-outstanding Wishbone classic-cycle initiator. Takes one
//             command over a valid/ready handshake, runs one read or write
//             cycle, and returns the result over a valid/ready response port.
//             A bus watchdog aborts cycles to hung slaves, and a saturating
//             counter tallies erroring responses.
//  Ports    : clk_i/rst_i          clock, synchronous active-high reset
//             cmd_*                command handshake (we/addr/data/sel)
//             rsp_*                response handshake (data/err/timeout)
//             err_count            saturating count of error responses
//             wb_*_o / wb_*_i      Wishbone initiator interface
//  Revision : 1.0 - initial release
// ============================================================================
module wb_master_bridge #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [DW-1:0]   cmd_data,
  input  logic [DW/8-1:0] cmd_sel,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_data,
  output logic            rsp_err,
  output logic            rsp_timeout,
  output logic [7:0]      err_count,
  output logic [AW-1:0]   wb_addr_o,
  output logic [DW-1:0]   wb_data_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic            wb_we_o,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  input  logic [DW-1:0]   wb_data_i,
  input  logic            wb_ack_i,
  input  logic            wb_err_i
);

  localparam logic [15:0] C_TIMEOUT = 16'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     wb_addr_q, wb_addr_d;
  logic [DW-1:0]     wb_data_q, wb_data_d;
  logic [DW/8-1:0]   wb_sel_q, wb_sel_d;
  logic              wb_we_q, wb_we_d;
  logic              wb_cyc_q, wb_cyc_d;
  logic              wb_stb_q, wb_stb_d;
  logic [DW-1:0]     rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic [7:0]        err_count_q, err_count_d;
  logic [15:0]       wdog_q, wdog_d;
  logic [15:0]       wdog_inc;

  assign cmd_ready = (state_q == ST_IDLE) && !rst_i;
  assign wdog_inc  = wdog_q + 16'd1;

  always_comb begin
    state_d       = state_q;
    wb_addr_d     = wb_addr_q;
    wb_data_d     = wb_data_q;
    wb_sel_d      = wb_sel_q;
    wb_we_d       = wb_we_q;
    wb_cyc_d      = wb_cyc_q;
    wb_stb_d      = wb_stb_q;
    rsp_data_d    = rsp_data_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    err_count_d   = err_count_q;
    wdog_d        = wdog_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          wb_addr_d = cmd_addr;
          wb_data_d = cmd_data;
          wb_sel_d  = cmd_sel;
          wb_we_d   = cmd_we;
          wb_cyc_d  = 1'b1;
          wb_stb_d  = 1'b1;
          wdog_d    = 16'd0;
          state_d   = ST_BUS;
        end
      end

      ST_BUS: begin
        wdog_d = wdog_inc;
        // Slave error beats ack; the watchdog only fires when neither arrives.
        if (wb_err_i) begin
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b0;
          rsp_data_d    = '0;
          state_d       = ST_RESP;
        end else if (wb_ack_i) begin
          rsp_err_d     = 1'b0;
          rsp_timeout_d = 1'b0;
          rsp_data_d    = wb_we_q ? '0 : wb_data_i;
          state_d       = ST_RESP;
        end else if (wdog_inc == C_TIMEOUT) begin
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_data_d    = '0;
          state_d       = ST_RESP;
        end

        if (state_d == ST_RESP) begin
          wb_cyc_d = 1'b0;
          wb_stb_d = 1'b0;
          wb_we_d  = 1'b0;
          if (rsp_err_d && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
          end
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      wb_addr_q     <= '0;
      wb_data_q     <= '0;
      wb_sel_q      <= '0;
      wb_we_q       <= 1'b0;
      wb_cyc_q      <= 1'b0;
      wb_stb_q      <= 1'b0;
      rsp_data_q    <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      err_count_q   <= 8'd0;
      wdog_q        <= 16'd0;
    end else begin
      state_q       <= state_d;
      wb_addr_q     <= wb_addr_d;
      wb_data_q     <= wb_data_d;
      wb_sel_q      <= wb_sel_d;
      wb_we_q       <= wb_we_d;
      wb_cyc_q      <= wb_cyc_d;
      wb_stb_q      <= wb_stb_d;
      rsp_data_q    <= rsp_data_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      err_count_q   <= err_count_d;
      wdog_q        <= wdog_d;
    end
  end

  // The response is valid exactly while parked in RESP.
  assign rsp_valid   = (state_q == ST_RESP);
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign err_count   = err_count_q;
  assign wb_addr_o   = wb_addr_q;
  assign wb_data_o   = wb_data_q;
  assign wb_sel_o    = wb_sel_q;
  assign wb_we_o     = wb_we_q;
  assign wb_cyc_o    = wb_cyc_q;
  assign wb_stb_o    = wb_stb_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_master_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_wb_master_bridge
//  Purpose  : Self-checking bench for wb_master_bridge. Directed and random
//             transactions against a transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_master_bridge;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 8;

  localparam int K_ACK  = 0;
  localparam int K_ERR  = 1;
  localparam int K_BOTH = 2;
  localparam int K_NONE = 3;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_we = 1'b0;
  logic [31:0]   cmd_addr = '0;
  logic [31:0]   cmd_data = '0;
  logic [3:0]    cmd_sel = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [31:0]   rsp_data;
  logic          rsp_err;
  logic          rsp_timeout;
  logic [7:0]    err_count;
  logic [31:0]   wb_addr_o;
  logic [31:0]   wb_data_o;
  logic [3:0]    wb_sel_o;
  logic          wb_we_o;
  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic [31:0]   wb_data_i = '0;
  logic          wb_ack_i = 1'b0;
  logic          wb_err_i = 1'b0;

  wb_master_bridge #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .err_count(err_count),
    .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_data_i(wb_data_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  always #5 clk_i = ~clk_i;

  int ntests = 0;
  int nfail  = 0;
  int m_errs = 0;      // model of the saturating error counter

  logic        c_we;
  logic [31:0] c_addr;
  logic [31:0] c_data;
  logic [3:0]  c_sel;
  bit          preloaded = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic rand_cmd();
    c_we   = 1'($urandom_range(0, 1));
    c_addr = $urandom;
    c_data = $urandom;
    c_sel  = 4'($urandom_range(0, 15));
  endtask

  task automatic drive_cmd();
    cmd_valid = 1'b1;
    cmd_we    = c_we;
    cmd_addr  = c_addr;
    cmd_data  = c_data;
    cmd_sel   = c_sel;
  endtask

  // One complete transaction. The slave answers on bus cycle waits+1 with the
  // given kind; the consumer withholds rsp_ready for 'hold' cycles.
  task automatic run_txn(input int waits, input int kind, input logic [31:0] rdata,
                         input int hold, input bit preload_next);
    logic        e_we;
    logic [31:0] e_addr, e_data, e_rdata;
    logic [3:0]  e_sel;
    int          n, guard, exp_n;
    bit          timed, exp_err;
    e_we = c_we; e_addr = c_addr; e_data = c_data; e_sel = c_sel;

    drive_cmd();
    guard = 0;
    while (!cmd_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) chk("cmd_ready_wait", 64'(cmd_ready), 64'd1);
    if (preloaded) chk("accept_after_handshake", 64'(guard), 64'd0);
    preloaded = 1'b0;

    tick();                       // acceptance edge
    cmd_valid = 1'b0;
    chk("bus_cyc", 64'(wb_cyc_o), 64'd1);
    chk("bus_stb", 64'(wb_stb_o), 64'd1);
    chk("bus_we", 64'(wb_we_o), 64'(e_we));
    chk("bus_addr", 64'(wb_addr_o), 64'(e_addr));
    chk("bus_data", 64'(wb_data_o), 64'(e_data));
    chk("bus_sel", 64'(wb_sel_o), 64'(e_sel));

    n = 0;
    guard = 0;
    while (wb_cyc_o && guard < 100) begin
      n++;
      if (kind != K_NONE && n == waits + 1) begin
        wb_ack_i  = (kind != K_ERR);
        wb_err_i  = (kind != K_ACK);
        wb_data_i = rdata;
      end else begin
        wb_ack_i  = 1'b0;
        wb_err_i  = 1'b0;
        wb_data_i = $urandom;
      end
      tick();
      guard++;
    end
    if (guard >= 100) chk("bus_bound", 64'(wb_cyc_o), 64'd0);
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;

    // Reference model of one transaction.
    timed   = (kind == K_NONE) || (waits + 1 > TMO);
    exp_n   = timed ? TMO : waits + 1;
    exp_err = timed || (kind != K_ACK);
    e_rdata = (!exp_err && !e_we) ? rdata : 32'd0;
    if (exp_err && m_errs < 255) m_errs++;

    chk("cyc_cycles", 64'(n), 64'(exp_n));
    chk("end_stb", 64'(wb_stb_o), 64'd0);
    chk("end_we", 64'(wb_we_o), 64'd0);
    chk("rsp_valid", 64'(rsp_valid), 64'd1);
    chk("rsp_data", 64'(rsp_data), 64'(e_rdata));
    chk("rsp_err", 64'(rsp_err), 64'(exp_err));
    chk("rsp_timeout", 64'(rsp_timeout), 64'(timed));
    chk("err_count", 64'(err_count), 64'(m_errs));

    if (preload_next) begin
      rand_cmd();
      drive_cmd();
      preloaded = 1'b1;
    end
    rsp_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      wb_ack_i = 1'($urandom_range(0, 1));   // stray responses must be ignored
      wb_err_i = 1'($urandom_range(0, 1));
      tick();
      chk("hold_valid", 64'(rsp_valid), 64'd1);
      chk("hold_data", 64'(rsp_data), 64'(e_rdata));
      chk("hold_err", 64'(rsp_err), 64'(exp_err));
      chk("hold_cmd_ready", 64'(cmd_ready), 64'd0);
      chk("hold_cyc", 64'(wb_cyc_o), 64'd0);
      chk("hold_err_count", 64'(err_count), 64'(m_errs));
    end
    wb_ack_i  = 1'b0;
    wb_err_i  = 1'b0;
    rsp_ready = 1'b1;
    tick();                       // handshake edge
    chk("post_valid", 64'(rsp_valid), 64'd0);
    chk("post_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("post_cyc", 64'(wb_cyc_o), 64'd0);
  endtask

  initial begin
    #10ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int g;
    // Reset state
    tick(); tick(); tick();
    chk("rst_cyc", 64'(wb_cyc_o), 64'd0);
    chk("rst_stb", 64'(wb_stb_o), 64'd0);
    chk("rst_valid", 64'(rsp_valid), 64'd0);
    chk("rst_err_count", 64'(err_count), 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_addr", 64'(wb_addr_o), 64'd0);
    rst_i = 1'b0;
    tick();
    chk("idle_cmd_ready", 64'(cmd_ready), 64'd1);

    // Stray ack/err in IDLE is ignored
    wb_ack_i = 1'b1; wb_err_i = 1'b1;
    tick();
    wb_ack_i = 1'b0; wb_err_i = 1'b0;
    chk("stray_idle_cyc", 64'(wb_cyc_o), 64'd0);
    chk("stray_idle_cnt", 64'(err_count), 64'd0);

    // Zero-wait write
    c_we = 1'b1; c_addr = 32'h10; c_data = 32'hDEADBEEF; c_sel = 4'hF;
    run_txn(0, K_ACK, 32'hCAFEF00D, 0, 1'b0);
    // Read with 3 wait states
    c_we = 1'b0; c_addr = 32'h20; c_data = 32'h0; c_sel = 4'hF;
    run_txn(3, K_ACK, 32'h12345678, 0, 1'b0);
    // Ack and err together
    rand_cmd();
    run_txn(1, K_BOTH, 32'h5555AAAA, 0, 1'b0);
    // Silent slave -> watchdog
    rand_cmd();
    run_txn(0, K_NONE, 32'h0, 0, 1'b0);
    // Ack on the last cycle before the watchdog would fire
    rand_cmd(); c_we = 1'b0;
    run_txn(TMO - 1, K_ACK, 32'hA5A5_0F0F, 0, 1'b0);
    // Back-pressure with a queued second command
    rand_cmd(); c_we = 1'b0;
    run_txn(0, K_ACK, 32'h0BADCAFE, 5, 1'b1);
    run_txn(2, K_ACK, $urandom, 0, 1'b0);

    // Random mix
    rand_cmd();
    for (int i = 0; i < 40; i++) begin
      run_txn($urandom_range(0, 10), $urandom_range(0, 3), $urandom,
              $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      if (!preloaded) rand_cmd();
    end

    // Saturation of the error counter
    for (int i = 0; i < 300; i++) begin
      rand_cmd();
      run_txn(0, K_NONE, 32'h0, 0, 1'b0);
    end
    chk("err_count_saturated", 64'(err_count), 64'd255);

    // Reset in the second bus cycle
    rand_cmd();
    drive_cmd();
    g = 0;
    while (!cmd_ready && g < 50) begin tick(); g++; end
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("rst_mid_cyc_before", 64'(wb_cyc_o), 64'd1);
    rst_i = 1'b1;
    tick();
    chk("rst_mid_cyc", 64'(wb_cyc_o), 64'd0);
    chk("rst_mid_stb", 64'(wb_stb_o), 64'd0);
    chk("rst_mid_valid", 64'(rsp_valid), 64'd0);
    chk("rst_mid_err_count", 64'(err_count), 64'd0);
    rst_i  = 1'b0;
    m_errs = 0;
    tick();
    chk("rst_mid_no_rsp", 64'(rsp_valid), 64'd0);
    rand_cmd(); c_we = 1'b0;
    run_txn(1, K_ACK, 32'h600DF00D, 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
`default_nettype wire
